fechadura_ctrl: RTL
===================

Name: fechadura_ctrl

Overview:
Sequencing controller for the lock's 8x8 register bank (R0 hardwired zero, R1–R7 writable, async read, write on clk rising edge).
- Initialises the stored 3-digit password.
- Writes keypad digits into the bank, then compares entry against password through the two read ports.
- Drives unlock/alarm status, tracks failed attempts and supports reprogramming while open.
- Sole master of the bank's write port and both read ports.
- Register map: R1–R3 password digits, R4–R6 entered digits, R7 fail count.

Parameters:
OPEN_CYCLES, 50, cycles unlocked stays high in OPEN.
LOCK_CYCLES, 100, cycles spent in LOCKOUT.
MAX_FAILS, 3, consecutive failed checks that trigger LOCKOUT (1..255).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
key_valid  in  1  one-cycle key strobe.
key_code  in  4  0–9 digit, 0xA enter, 0xB clear, 0xC program, others ignored.
rd1  in  8  bank read data for ra1.
rd2  in  8  bank read data for ra2.
we3  out  1  bank write enable.
wa3  out  3  bank write address.
wd3  out  8  bank write data.
ra1  out  3  bank read address 1.
ra2  out  3  bank read address 2.
unlocked  out  1  lock open.
alarm  out  1  high during LOCKOUT.
busy  out  1  high in INIT, CHECK, LOCKOUT.
digit_count  out  2  digits held in current entry (0–3).

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - state INIT, all outputs 0, fail counter 0, timer 0, mismatch flag 0.
  - Reset mid-operation aborts everything. Bank contents are not cleared; INIT rewrites them.
- INIT, 4 cycles, one write per cycle: R1=1, R2=2, R3=3, R7=0, in that order. Then IDLE.
- IDLE/ENTRY, key sampled only when key_valid=1:
  - Digit with count<3: write zero-extended digit to R(4+count); count+1; state ENTRY. Digit with count=3: ignored, no write.
  - Clear: count=0, no write.
  - Enter with count=3: go to CHECK.
  - Enter with count<3: counts as a failed attempt (fail handling below), count=0.
- CHECK, exactly 3 cycles, k=0,1,2:
  - ra1=1+k, ra2=4+k; mismatch |= (rd1!=rd2).
  - After k=2, count=0.
  - No mismatch: fail counter=0, write R7=0, go to OPEN.
  - Mismatch: fail handling.
- Fail handling:
  - fail counter+1 (saturating at 255); write R7=new value.
  - If new value >= MAX_FAILS: LOCKOUT, fail counter=0, R7=0 written on LOCKOUT exit.
  - Otherwise: IDLE.
- Timing: Enter sampled at edge t -> CHECK during cycles t+1..t+3 -> unlocked=1 from edge t+4.
- OPEN:
  - unlocked=1 for OPEN_CYCLES cycles, then IDLE.
  - key 0xC enters PROG (unlocked stays 1); other keys ignored.
- PROG:
  - Digits written to R1, R2, R3 in order.
  - After the 3rd write: IDLE, unlocked=0.
  - Clear aborts to IDLE with partial writes kept.
  - Timer frozen while in PROG.
- LOCKOUT: alarm=1 and busy=1 for LOCK_CYCLES cycles; all keys ignored. Then write R7=0 and go to IDLE.
- Bank port rules:
  - we3 is high for exactly one cycle per write.
  - wa3 is never 0.
  - At most one write per cycle.
  - When idle: we3=0, ra1=ra2=0.
- key_valid during busy is dropped, never queued.

Test Plan:
1. Release rst_n -> 4 writes (R1=1,R2=2,R3=3,R7=0) on consecutive edges; busy=1 for 4 cycles; then IDLE.
2. Keys 1,2,3,Enter -> writes R4..R6=1,2,3; ra1/ra2 sequence 1/4, 2/5, 3/6; unlocked=1 at edge t+4, held 50 cycles.
3. Keys 1,2,4,Enter three times -> R7 written 1, 2, then LOCKOUT; alarm=1 for 100 cycles; keys ignored; R7=0 on exit.
4. Keys 5,Enter -> no CHECK, R7=1, digit_count=0; keys 1,2,3,3,3,Enter -> extra digits ignored, unlocks, R7=0.
5. In OPEN, keys 0xC,7,8,9 -> R1..R3=7,8,9, unlocked falls; 1,2,3,Enter fails, 7,8,9,Enter unlocks.
6. Assert rst_n low during CHECK cycle k=1 -> outputs 0 immediately; INIT replays, password back to 1,2,3.

Source files
------------

// File: rtl/fechadura_ctrl.sv
// rtl/fechadura_ctrl.sv - lock sequencing controller: password init, keypad entry, compare, unlock/alarm
// Owns all three ports of the external 8x8 register bank; every output is registered.
module fechadura_ctrl #(
   parameter int OPEN_CYCLES = 50,
   parameter int LOCK_CYCLES = 100,
   parameter int MAX_FAILS   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic [7:0] rd1,
   input  logic [7:0] rd2,
   output logic       we3,
   output logic [2:0] wa3,
   output logic [7:0] wd3,
   output logic [2:0] ra1,
   output logic [2:0] ra2,
   output logic       unlocked,
   output logic       alarm,
   output logic       busy,
   output logic [1:0] digit_count
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_OPEN,
      S_PROG,
      S_LOCKOUT
   } state_t;

   localparam logic [3:0]  KEY_ENTER  = 4'hA;
   localparam logic [3:0]  KEY_CLEAR  = 4'hB;
   localparam logic [3:0]  KEY_PROG   = 4'hC;
   localparam logic [2:0]  REG_FAILS  = 3'd7;
   localparam logic [15:0] OPEN_LOAD  = 16'(OPEN_CYCLES - 1);
   localparam logic [15:0] LOCK_LOAD  = 16'(LOCK_CYCLES - 1);
   localparam logic [7:0]  FAIL_LIMIT = 8'(MAX_FAILS);

   state_t      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [15:0] timer_q, timer_d;
   logic [7:0]  fails_q, fails_d;
   logic        mismatch_q, mismatch_d;
   logic        we3_q, we3_d;
   logic [2:0]  wa3_q, wa3_d;
   logic [7:0]  wd3_q, wd3_d;
   logic [2:0]  ra1_q, ra1_d;
   logic [2:0]  ra2_q, ra2_d;
   logic        unlocked_q, unlocked_d;
   logic        alarm_q, alarm_d;
   logic        busy_q, busy_d;
   logic [1:0]  count_q, count_d;

   logic        is_digit;
   logic        pair_differs;
   logic        fail_now;
   logic [7:0]  fails_inc;

   assign is_digit     = (key_code <= 4'd9);
   assign pair_differs = (rd1 != rd2);
   assign fails_inc    = (fails_q == 8'hFF) ? fails_q : fails_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         step_q     <= 2'd0;
         timer_q    <= 16'd0;
         fails_q    <= 8'd0;
         mismatch_q <= 1'b0;
         we3_q      <= 1'b0;
         wa3_q      <= 3'd0;
         wd3_q      <= 8'd0;
         ra1_q      <= 3'd0;
         ra2_q      <= 3'd0;
         unlocked_q <= 1'b0;
         alarm_q    <= 1'b0;
         busy_q     <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         timer_q    <= timer_d;
         fails_q    <= fails_d;
         mismatch_q <= mismatch_d;
         we3_q      <= we3_d;
         wa3_q      <= wa3_d;
         wd3_q      <= wd3_d;
         ra1_q      <= ra1_d;
         ra2_q      <= ra2_d;
         unlocked_q <= unlocked_d;
         alarm_q    <= alarm_d;
         busy_q     <= busy_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      timer_d    = timer_q;
      fails_d    = fails_q;
      mismatch_d = mismatch_q;
      we3_d      = 1'b0;
      wa3_d      = wa3_q;
      wd3_d      = wd3_q;
      ra1_d      = 3'd0;
      ra2_d      = 3'd0;
      unlocked_d = 1'b0;
      alarm_d    = 1'b0;
      busy_d     = 1'b0;
      count_d    = count_q;
      fail_now   = 1'b0;

      case (state_q)
         S_INIT: begin
            we3_d  = 1'b1;
            busy_d = 1'b1;
            case (step_q)
               2'd0:    begin wa3_d = 3'd1;      wd3_d = 8'd1; end
               2'd1:    begin wa3_d = 3'd2;      wd3_d = 8'd2; end
               2'd2:    begin wa3_d = 3'd3;      wd3_d = 8'd3; end
               default: begin wa3_d = REG_FAILS; wd3_d = 8'd0; end
            endcase
            if (step_q == 2'd3) begin
               step_d  = 2'd0;
               state_d = S_IDLE;
            end else begin
               step_d = step_q + 2'd1;
            end
         end

         S_IDLE, S_ENTRY: begin
            if (key_valid) begin
               if (is_digit) begin
                  if (count_q != 2'd3) begin
                     we3_d   = 1'b1;
                     wa3_d   = 3'd4 + {1'b0, count_q};
                     wd3_d   = {4'd0, key_code};
                     count_d = count_q + 2'd1;
                     state_d = S_ENTRY;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  count_d = 2'd0;
                  state_d = S_IDLE;
               end else if (key_code == KEY_ENTER) begin
                  if (count_q == 2'd3) begin
                     step_d     = 2'd0;
                     mismatch_d = 1'b0;
                     busy_d     = 1'b1;
                     state_d    = S_CHECK;
                  end else begin
                     count_d  = 2'd0;
                     fail_now = 1'b1;
                  end
               end
            end
         end

         // Step 0 issues the first address pair; read data for a pair is
         // compared on the following step, so step 3 only compares and decides.
         S_CHECK: begin
            busy_d = 1'b1;
            if (step_q != 2'd3) begin
               if (step_q != 2'd0) begin
                  mismatch_d = mismatch_q | pair_differs;
               end
               ra1_d  = 3'd1 + {1'b0, step_q};
               ra2_d  = 3'd4 + {1'b0, step_q};
               step_d = step_q + 2'd1;
            end else begin
               step_d     = 2'd0;
               mismatch_d = 1'b0;
               count_d    = 2'd0;
               if (mismatch_q | pair_differs) begin
                  fail_now = 1'b1;
               end else begin
                  fails_d    = 8'd0;
                  we3_d      = 1'b1;
                  wa3_d      = REG_FAILS;
                  wd3_d      = 8'd0;
                  busy_d     = 1'b0;
                  unlocked_d = 1'b1;
                  timer_d    = OPEN_LOAD;
                  state_d    = S_OPEN;
               end
            end
         end

         S_OPEN: begin
            unlocked_d = 1'b1;
            if (timer_q == 16'd0) begin
               unlocked_d = 1'b0;
               state_d    = S_IDLE;
            end else begin
               timer_d = timer_q - 16'd1;
               if (key_valid && (key_code == KEY_PROG)) begin
                  step_d  = 2'd0;
                  state_d = S_PROG;
               end
            end
         end

         // Timer is left untouched here; every exit from PROG goes to IDLE.
         S_PROG: begin
            unlocked_d = 1'b1;
            if (key_valid) begin
               if (is_digit) begin
                  we3_d = 1'b1;
                  wa3_d = 3'd1 + {1'b0, step_q};
                  wd3_d = {4'd0, key_code};
                  if (step_q == 2'd2) begin
                     step_d     = 2'd0;
                     unlocked_d = 1'b0;
                     state_d    = S_IDLE;
                  end else begin
                     step_d = step_q + 2'd1;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  step_d     = 2'd0;
                  unlocked_d = 1'b0;
                  state_d    = S_IDLE;
               end
            end
         end

         S_LOCKOUT: begin
            alarm_d = 1'b1;
            busy_d  = 1'b1;
            if (timer_q == 16'd0) begin
               alarm_d = 1'b0;
               busy_d  = 1'b0;
               we3_d   = 1'b1;
               wa3_d   = REG_FAILS;
               wd3_d   = 8'd0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end

         default: begin
            state_d = S_INIT;
            step_d  = 2'd0;
         end
      endcase

      // Shared by a short Enter and a failed compare.
      if (fail_now) begin
         we3_d = 1'b1;
         wa3_d = REG_FAILS;
         wd3_d = fails_inc;
         if (fails_inc >= FAIL_LIMIT) begin
            fails_d = 8'd0;
            timer_d = LOCK_LOAD;
            alarm_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_LOCKOUT;
         end else begin
            fails_d = fails_inc;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      end
   end

   assign we3         = we3_q;
   assign wa3         = wa3_q;
   assign wd3         = wd3_q;
   assign ra1         = ra1_q;
   assign ra2         = ra2_q;
   assign unlocked    = unlocked_q;
   assign alarm       = alarm_q;
   assign busy        = busy_q;
   assign digit_count = count_q;

endmodule
